// File: rtl/inv_chain_meas_pkg.sv
// Shared types and defaults for the inverter-chain delay measurement block.
package inv_chain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/inv_chain_meas_sync_ff.sv
// Multi-flop synchronizer for the asynchronous chain output; resets to 0.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge ck) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/inv_chain_meas.sv
// Launches an edge into an external inverter chain and counts clock cycles
// until the synchronized chain output reflects it (or the counter saturates).
module inv_chain_meas
  import inv_chain_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int INVERTING   = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  output logic             i_dut,
  input  logic             nq_dut,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic               i_dut_q, i_dut_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               res_timeout_q, res_timeout_d;
  logic               nq_s;
  logic               match;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
    .ck (ck),
    .rst(rst),
    .d  (nq_dut),
    .q  (nq_s)
  );

  // The launched edge has arrived once the sync output shows the chain's
  // steady-state response to the current drive level.
  assign match = (INVERTING != 0) ? (nq_s == ~i_dut_q) : (nq_s == i_dut_q);

  always_comb begin
    state_d       = state_q;
    i_dut_d       = i_dut_q;
    cnt_d         = cnt_q;
    res_count_d   = res_count_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_dut_d = ~i_dut_q;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (match) begin
          res_count_d   = cnt_q;
          res_timeout_d = 1'b0;
          state_d       = DONE;
        end else if (cnt_q == CNT_MAX) begin
          res_count_d   = CNT_MAX;
          res_timeout_d = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q       <= IDLE;
      i_dut_q       <= 1'b0;
      cnt_q         <= '0;
      res_count_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_dut_q       <= i_dut_d;
      cnt_q         <= cnt_d;
      res_count_q   <= res_count_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign i_dut       = i_dut_q;
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign res_count   = res_count_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_inv_chain_meas.sv
// Bench: directed scenarios plus random traffic, checked every cycle against a
// behavioural model of the measurement protocol.
module tb_inv_chain_meas;
  localparam int CW = 4;
  localparam int SS = 2;

  logic ck = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic i_dut, nq_dut, busy, res_valid, res_timeout;
  logic [CW-1:0] res_count;
  logic start2 = 1'b0, res_ready2 = 1'b0;
  logic i2, nq2, busy2, valid2, to2;
  logic [7:0] cnt2;

  int checks = 0, errors = 0;

  // chain model: 0 = combinational inverter, N = N-cycle registered delay, or stuck
  int chain_d = 0;
  bit stuck = 0, stuck_v = 0;
  logic [7:0] dly = '0;

  always #5 ck = ~ck;

  always @(posedge ck) dly <= {dly[6:0], i_dut};
  always_comb nq_dut = stuck ? stuck_v : (chain_d == 0 ? ~i_dut : ~dly[chain_d-1]);
  assign nq2 = i2;

  inv_chain_meas #(.CNT_W(CW), .SYNC_STAGES(SS), .INVERTING(1)) dut (
    .ck(ck), .rst(rst), .start(start), .i_dut(i_dut), .nq_dut(nq_dut),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_timeout(res_timeout)
  );

  inv_chain_meas #(.INVERTING(0)) dut_buf (
    .ck(ck), .rst(rst), .start(start2), .i_dut(i2), .nq_dut(nq2),
    .busy(busy2), .res_valid(valid2), .res_ready(res_ready2),
    .res_count(cnt2), .res_timeout(to2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: nq_s is nq_dut as seen SS edges ago.
  bit m_busy = 0, m_valid = 0, m_i = 0, m_to = 0, m_match = 0, cmp_en = 0;
  int m_cnt = 0;
  logic [CW-1:0] m_rc = '0;
  bit m_hist [SS];

  always @(posedge ck) begin
    m_match = (m_hist[SS-1] == !m_i);
    for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = (nq_dut === 1'b1);
    if (rst) begin
      m_busy = 0; m_valid = 0; m_i = 0; m_to = 0; m_cnt = 0; m_rc = '0;
      for (int k = 0; k < SS; k++) m_hist[k] = 0;
      cmp_en = 1;
    end else if (!m_busy) begin
      if (start) begin m_i = !m_i; m_cnt = 0; m_busy = 1; end
    end else if (!m_valid) begin
      if (m_match) begin m_rc = CW'(m_cnt); m_to = 0; m_valid = 1; end
      else if (m_cnt == (1 << CW) - 1) begin m_rc = '1; m_to = 1; m_valid = 1; end
      else m_cnt++;
    end else if (res_ready) begin
      m_busy = 0; m_valid = 0;
    end
  end

  always @(negedge ck) begin
    if (cmp_en) begin
      chk("m_i_dut", i_dut, m_i);
      chk("m_busy", busy, m_busy);
      chk("m_res_valid", res_valid, m_valid);
      chk("m_res_count", res_count, m_rc);
      chk("m_res_timeout", res_timeout, m_to);
    end
  end

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int k = 0; k < 100 && !res_valid; k++) begin
      cyc++;
      @(negedge ck);
    end
    chk("valid_seen", res_valid, 1);
  endtask

  task automatic do_meas(input string nm, input int exp_i, input int exp_cnt);
    int cyc;
    start = 1; @(negedge ck); start = 0;
    chk({nm, "_i_dut"}, i_dut, exp_i);
    wait_valid(cyc);
    chk({nm, "_count"}, res_count, exp_cnt);
    chk({nm, "_timeout"}, res_timeout, 0);
    res_ready = 1; @(negedge ck); res_ready = 0;
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc;
    rst = 1;
    repeat (3) @(negedge ck);
    chk("rst_i_dut", i_dut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", res_count, 0);
    chk("rst_timeout", res_timeout, 0);
    rst = 0;
    repeat (4) @(negedge ck);

    chain_d = 0;
    do_meas("zero", 1, SS);

    start2 = 1; @(negedge ck); start2 = 0;
    for (int k = 0; k < 50 && !valid2; k++) @(negedge ck);
    chk("buf_valid", valid2, 1);
    chk("buf_count", cnt2, 2);
    chk("buf_timeout", to2, 0);
    res_ready2 = 1; @(negedge ck); res_ready2 = 0;

    chain_d = 5;
    repeat (8) @(negedge ck);
    do_meas("d5a", 0, 7);
    repeat (8) @(negedge ck);
    do_meas("d5b", 1, 7);

    // stuck output: never matches, must saturate; start pulses must be ignored
    stuck_v = !i_dut; stuck = 1;
    repeat (4) @(negedge ck);
    start = 1; @(negedge ck); start = 0;
    chk("to_i_dut", i_dut, 0);
    cyc = 0;
    for (int k = 0; k < 100 && !res_valid; k++) begin
      cyc++;
      start = (k % 5 == 2);
      @(negedge ck);
    end
    start = 0;
    chk("to_valid", res_valid, 1);
    chk("to_wait_cycles", cyc, 16);
    chk("to_count", res_count, 15);
    chk("to_timeout", res_timeout, 1);
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      @(negedge ck);
      chk("hold_valid", res_valid, 1);
      chk("hold_count", res_count, 15);
      chk("hold_i_dut", i_dut, 0);
    end
    res_ready = 1; start = 1; @(negedge ck); res_ready = 0; start = 0;
    chk("ready_start_busy", busy, 0);
    @(negedge ck);
    chk("ready_start_ignored", busy, 0);
    chk("ready_start_i_dut", i_dut, 0);

    // reset in the third WAIT cycle
    stuck_v = !i_dut;
    repeat (4) @(negedge ck);
    start = 1; @(negedge ck); start = 0;
    chk("rw_i_dut", i_dut, 1);
    repeat (2) @(negedge ck);
    rst = 1; @(negedge ck); rst = 0;
    chk("rw_i_dut_rst", i_dut, 0);
    chk("rw_busy", busy, 0);
    chk("rw_valid", res_valid, 0);

    stuck = 0; chain_d = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 200) == 0;
      start = ($urandom % 4) == 0;
      res_ready = ($urandom % 3) == 0;
      if (($urandom % 50) == 0) begin
        chain_d = int'($urandom % 7);
        stuck = ($urandom % 4) == 0;
        stuck_v = $urandom % 2;
      end
      @(negedge ck);
    end
    rst = 0; start = 0; res_ready = 0;
    @(negedge ck);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_chain_meas.md
INV_CHAIN_MEAS -- requirements
Module: inv_chain_meas

Interface
REQ-001 Parameter CNT_W, default 8: width of the delay counter and result.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..3: depth of the flop synchronizer on nq_dut.
REQ-003 Parameter INVERTING, default 1: 1 means the chain under test has odd inversion (expected nq_dut = ~i_dut); 0 means even inversion (expected nq_dut = i_dut).
REQ-004 Port ck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port start, input, 1 bit: request one measurement; sampled only in IDLE.
REQ-007 Port i_dut, output, 1 bit: registered drive to the inverter-chain input.
REQ-008 Port nq_dut, input, 1 bit: inverter-chain output, treated as asynchronous.
REQ-009 Port busy, output, 1 bit: high in every state except IDLE.
REQ-010 Port res_valid, output, 1 bit: result available.
REQ-011 Port res_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port res_count, output, CNT_W bits: measured cycles.
REQ-013 Port res_timeout, output, 1 bit: measurement saturated without a match.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, WAIT and DONE.
REQ-015 In IDLE with start=1, the next edge SHALL toggle i_dut, clear cnt to 0, and enter WAIT; start SHALL be ignored in WAIT and DONE.
REQ-016 nq_dut SHALL pass through SYNC_STAGES flops before any comparison; this sync output is nq_s.
REQ-017 match SHALL be (nq_s == ~i_dut) when INVERTING=1, else (nq_s == i_dut).
REQ-018 In WAIT with match=1, the next edge SHALL load res_count=cnt and res_timeout=0, then enter DONE.
REQ-019 In WAIT with match=0 and cnt<2^CNT_W-1, the next edge SHALL increment cnt.
REQ-020 In WAIT with match=0 and cnt=2^CNT_W-1, the next edge SHALL load res_count=2^CNT_W-1 and res_timeout=1, then enter DONE; cnt SHALL never wrap.
REQ-021 res_valid SHALL be high exactly in DONE; res_count and res_timeout SHALL stay stable while res_valid=1.
REQ-022 In DONE with res_ready=1, the next edge SHALL enter IDLE; res_ready SHALL be ignored outside DONE.
REQ-023 A res_ready in DONE together with a start on the same cycle SHALL NOT start a new measurement; start is honoured only from the following IDLE cycle.
REQ-024 For a zero-delay chain, res_count SHALL equal SYNC_STAGES, so latency is counted including synchronizer depth.
REQ-025 i_dut SHALL hold its value in WAIT, DONE and IDLE and SHALL change only on the IDLE->WAIT transition.

Reset
REQ-026 With rst=1 at an edge, the block SHALL set: state=IDLE, i_dut=0, cnt=0, res_count=0, res_timeout=0, sync flops=0, busy=0, res_valid=0.
REQ-027 rst SHALL take priority over every other input in every state, including mid-WAIT and mid-DONE; any pending result is discarded.

Structure
REQ-028 A shared package inv_chain_pkg SHALL hold the state enum (IDLE, WAIT, DONE) and the default CNT_W and SYNC_STAGES constants.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_ff, with a depth parameter, ck, rst, d and q.
REQ-030 The implementation SHALL contain no combinational path from nq_dut to any output.

Verification
REQ-031 Zero-delay chain (nq_dut=~i_dut), SYNC_STAGES=2, pulse start -> i_dut goes 0->1, then res_valid with res_count=2 and res_timeout=0.
REQ-032 Chain modelled as a 5-cycle delay -> res_count=7; a second start gives i_dut 1->0 and res_count=7.
REQ-033 nq_dut stuck so no match, CNT_W=4 -> res_valid with res_count=15 and res_timeout=1 after 16 WAIT cycles.
REQ-034 res_ready held low 10 cycles in DONE -> res_valid and res_count stable throughout; start pulses during WAIT and DONE are ignored (i_dut unchanged).
REQ-035 rst asserted in cycle 3 of WAIT -> next cycle state=IDLE, i_dut=0, busy=0, res_valid=0.
REQ-036 INVERTING=0 with a buffer model (nq_dut=i_dut) -> res_count=2 and res_timeout=0.
